fb_sgnl_recorder: RTL and testbench
===================================

FB_SGNL_RECORDER -- requirements
Module: fb_sgnl_recorder

Interface
REQ-001 Parameter DEPTH, 64, number of capture entries (power of two, 8..256).
REQ-002 Parameter CW, 7, counter width; SHALL equal log2(DEPTH)+1.
REQ-003 clk  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 store_strb  in  1  beam store window, same clock domain.
REQ-006 fb_valid  in  1  one-cycle pulse; fb_sgnl/oflow carry a new DAC word this cycle.
REQ-007 fb_sgnl  in  13  signed two's-complement feedback DAC word.
REQ-008 oflow  in  1  overflow flag accompanying fb_sgnl.
REQ-009 rd_start  in  1  request readout of the captured record.
REQ-010 rd_ready  in  1  consumer accepts rd_data this cycle.
REQ-011 rd_valid  out  1  rd_data valid.
REQ-012 rd_data  out  14  {oflow, fb_sgnl} of the current entry.
REQ-013 rd_last  out  1  current entry is the final captured entry.
REQ-014 n_samples  out  CW  entries captured in the last window (0..DEPTH).
REQ-015 peak_abs  out  13  unsigned max |fb_sgnl| over captured entries.
REQ-016 oflow_cnt  out  CW  captured entries with oflow=1.
REQ-017 done  out  1  record complete and readable.
REQ-018 overrun  out  1  fb_valid seen while buffer full.

Function
REQ-019 States SHALL be IDLE, CAPTURE, HOLD, READ; all outputs registered.
REQ-020 Arm edge: store_strb=1 this cycle and 0 the previous cycle (previous-value register, reset to 0).
REQ-021 IDLE/HOLD/READ + arm edge -> CAPTURE next cycle; n_samples, peak_abs, oflow_cnt, overrun, done cleared; rd_valid deasserted; unread data discarded.
REQ-022 CAPTURE: each cycle with fb_valid=1 and store_strb=1 and n_samples<DEPTH writes {oflow,fb_sgnl} at address n_samples; n_samples increments by 1 the following cycle.
REQ-023 Same write: peak_abs <= max(peak_abs, |fb_sgnl|); |-4096| SHALL be 4096 (13-bit unsigned, no wrap); oflow_cnt increments when oflow=1.
REQ-024 fb_valid=1 with n_samples=DEPTH: no write, counters unchanged, overrun <= 1 (sticky until next arm edge or reset).
REQ-025 fb_valid=1 in the cycle store_strb is 0 SHALL be ignored.
REQ-026 CAPTURE with store_strb=0 -> HOLD; done <= 1 in that transition (first HOLD cycle).
REQ-027 HOLD + rd_start=1 + n_samples>0 -> READ; n_samples=0: rd_start ignored, stay HOLD.
REQ-028 rd_valid SHALL first assert exactly 2 cycles after the cycle rd_start is sampled, presenting entry 0.
REQ-029 Transfer occurs when rd_valid & rd_ready; next entry presented the following cycle; with rd_ready held 1 the block SHALL sustain one entry per cycle with no bubbles.
REQ-030 rd_valid=1 & rd_ready=0: rd_data, rd_last held stable.
REQ-031 rd_last=1 exactly while presenting entry n_samples-1; after its transfer rd_valid <= 0 next cycle, state -> HOLD, read pointer <= 0 (record may be re-read; done stays 1).
REQ-032 rd_start in IDLE, CAPTURE or READ SHALL be ignored.
REQ-033 Arm edge during READ aborts readout: rd_valid 0 the next cycle, no further transfers.

Reset
REQ-034 rst=1 at any clock edge, including mid-capture or mid-read: state IDLE; rd_valid, rd_last, done, overrun 0; n_samples, peak_abs, oflow_cnt, read pointer 0; store_strb history 0.
REQ-035 Buffer contents need not be cleared; no entry is readable until a new capture completes.
REQ-036 store_strb=1 held through deassertion of rst SHALL not arm; a fresh 0->1 edge is required.

Verification
REQ-037 Arm, 3 fb_valid pulses with fb_sgnl = 100, -4096, 4095 (oflow 0,1,0), drop store_strb -> done=1, n_samples=3, peak_abs=4096, oflow_cnt=1, overrun=0.
REQ-038 After REQ-037, rd_start pulse, rd_ready=1 -> rd_valid rises 2 cycles later; data 0x0064, 0x3000, 0x0FFF on 3 consecutive cycles; rd_last only on the third; state back to HOLD.
REQ-039 DEPTH+2 fb_valid pulses in one window -> n_samples=DEPTH, overrun=1, entries 0..DEPTH-1 equal the first DEPTH words.
REQ-040 Readout with rd_ready toggling 1,0,0,1 -> each entry transferred exactly once, rd_data stable during stall cycles.
REQ-041 rst asserted mid-READ, then new window with 1 sample (-1) -> all outputs zero after rst; readout returns single word 0x1FFF with rd_last=1.
REQ-042 Window with zero fb_valid pulses, then rd_start -> done=1, n_samples=0, rd_valid never asserts.

Source files
------------

// File: rtl/fb_sgnl_recorder.sv
`timescale 1ns/1ps
// Feedback DAC word recorder: captures {oflow, fb_sgnl} during a beam store
// window, keeps simple statistics, then streams the record out on request.
module fb_sgnl_recorder #(
  parameter int DEPTH = 64,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          store_strb,
  input  logic          fb_valid,
  input  logic [12:0]   fb_sgnl,
  input  logic          oflow,
  input  logic          rd_start,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [13:0]   rd_data,
  output logic          rd_last,
  output logic [CW-1:0] n_samples,
  output logic [12:0]   peak_abs,
  output logic [CW-1:0] oflow_cnt,
  output logic          done,
  output logic          overrun
);

  localparam int            AW   = CW - 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, READ} state_t;

  state_t        state, state_nxt;
  logic          store_prev;
  logic          arm_en;
  logic          arm;
  logic          arm_go;
  logic          wr_en;
  logic          ovr_hit;
  logic          xfer;
  logic          fetch;
  logic [12:0]   fb_abs;
  logic [CW-1:0] rd_ptr;
  logic [13:0]   mem [DEPTH];

  // arm_en stays low until store_strb has been seen low, so a strobe held
  // high across reset release does not count as a fresh edge.
  assign arm    = store_strb & ~store_prev & arm_en;
  assign arm_go = arm & (state != CAPTURE);
  assign xfer   = rd_valid & rd_ready;

  // Decode write/overrun qualifiers, magnitude, and output-register fetch.
  always_comb begin
    wr_en   = 1'b0;
    ovr_hit = 1'b0;
    fetch   = 1'b0;
    fb_abs  = fb_sgnl[12] ? (~fb_sgnl + 13'd1) : fb_sgnl;
    if (state == CAPTURE && fb_valid && store_strb) begin
      wr_en   = (n_samples != FULL);
      ovr_hit = (n_samples == FULL);
    end
    // Output register is (re)loaded on entry to READ and after every
    // non-final transfer, giving one entry per cycle with rd_ready held.
    if (state == READ && !arm_go)
      fetch = ~rd_valid | (xfer & ~rd_last);
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm) state_nxt = CAPTURE;
      CAPTURE: if (!store_strb) state_nxt = HOLD;
      HOLD: begin
        if (arm)                                   state_nxt = CAPTURE;
        else if (rd_start && n_samples != '0)      state_nxt = READ;
      end
      READ: begin
        if (arm)                   state_nxt = CAPTURE;
        else if (xfer && rd_last)  state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // store_strb history for arm-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      store_prev <= 1'b0;
      arm_en     <= ~store_strb;
    end else begin
      store_prev <= store_strb;
      arm_en     <= arm_en | ~store_strb;
    end
  end

  // Capture buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[n_samples[AW-1:0]] <= {oflow, fb_sgnl};
  end

  // Window statistics and status flags.
  always_ff @(posedge clk) begin
    if (rst || arm_go) begin
      n_samples <= '0;
      peak_abs  <= '0;
      oflow_cnt <= '0;
      overrun   <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (wr_en) begin
        n_samples <= n_samples + CW'(1);
        oflow_cnt <= oflow_cnt + {{(CW-1){1'b0}}, oflow};
        if (fb_abs > peak_abs) peak_abs <= fb_abs;
      end
      if (ovr_hit) overrun <= 1'b1;
      if (state == CAPTURE && !store_strb) done <= 1'b1;
    end
  end

  // Readout output register and read pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      rd_ptr   <= '0;
    end else if (arm_go) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_ptr   <= '0;
    end else if (fetch) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[rd_ptr[AW-1:0]];
      rd_last  <= (rd_ptr == n_samples - CW'(1));
      rd_ptr   <= rd_ptr + CW'(1);
    end else if (state == READ && xfer && rd_last) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_ptr   <= '0;
    end
  end

endmodule

// File: tb/tb_fb_sgnl_recorder.sv
`timescale 1ns/1ps
// Self-checking bench for fb_sgnl_recorder against a queue-based record model.
module tb_fb_sgnl_recorder;

  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          store_strb = 1'b0;
  logic          fb_valid = 1'b0;
  logic [12:0]   fb_sgnl = '0;
  logic          oflow = 1'b0;
  logic          rd_start = 1'b0;
  logic          rd_ready = 1'b0;
  logic          rd_valid;
  logic [13:0]   rd_data;
  logic          rd_last;
  logic [CW-1:0] n_samples;
  logic [12:0]   peak_abs;
  logic [CW-1:0] oflow_cnt;
  logic          done;
  logic          overrun;

  int n_cmp = 0;
  int n_bad = 0;
  logic [13:0] stim_q[$];
  logic [13:0] exp_q[$];
  bit          exp_ovr;

  fb_sgnl_recorder #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .store_strb(store_strb), .fb_valid(fb_valid),
    .fb_sgnl(fb_sgnl), .oflow(oflow), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .n_samples(n_samples), .peak_abs(peak_abs), .oflow_cnt(oflow_cnt),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_peak();
    int p;
    int v;
    logic [13:0] w;
    logic [12:0] s;
    p = 0;
    foreach (exp_q[i]) begin
      w = exp_q[i];
      s = w[12:0];
      v = $signed(s);
      if (v < 0) v = -v;
      if (v > p) p = v;
    end
    return p;
  endfunction

  function automatic int model_ocnt();
    int c;
    logic [13:0] w;
    c = 0;
    foreach (exp_q[i]) begin
      w = exp_q[i];
      if (w[13]) c++;
    end
    return c;
  endfunction

  task automatic gen_random(input int n);
    logic [13:0] w;
    stim_q.delete();
    repeat (n) begin
      w = 14'($urandom);
      case ($urandom_range(0, 7))
        0: w[12:0] = 13'h1000;
        1: w[12:0] = 13'h0FFF;
        default: ;
      endcase
      stim_q.push_back(w);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_rd_valid"},  rd_valid, 0);
    chk({pfx, "_rd_last"},   rd_last, 0);
    chk({pfx, "_done"},      done, 0);
    chk({pfx, "_overrun"},   overrun, 0);
    chk({pfx, "_n_samples"}, n_samples, 0);
    chk({pfx, "_peak_abs"},  peak_abs, 0);
    chk({pfx, "_oflow_cnt"}, oflow_cnt, 0);
  endtask

  task automatic check_stats();
    chk("win_done",      done, 1);
    chk("win_n_samples", n_samples, exp_q.size());
    chk("win_peak_abs",  peak_abs, model_peak());
    chk("win_oflow_cnt", oflow_cnt, model_ocnt());
    chk("win_overrun",   overrun, exp_ovr);
  endtask

  // Runs one store window with the words in stim_q, random gaps, random
  // (ignored) rd_start during capture, and an ignored pulse on the drop cycle.
  task automatic run_window(input bit armed);
    if (!armed) begin
      store_strb = 1'b1;
      fb_valid   = 1'b0;
      step();
    end
    foreach (stim_q[i]) begin
      repeat ($urandom_range(0, 2)) begin
        fb_valid = 1'b0;
        fb_sgnl  = 13'($urandom);
        rd_start = 1'($urandom_range(0, 1));
        step();
      end
      fb_valid = 1'b1;
      {oflow, fb_sgnl} = stim_q[i];
      step();
    end
    store_strb = 1'b0;
    fb_valid   = 1'b1;
    {oflow, fb_sgnl} = 14'($urandom);
    step();
    fb_valid = 1'b0;
    rd_start = 1'b0;
    exp_q.delete();
    foreach (stim_q[i]) if (exp_q.size() < DEPTH) exp_q.push_back(stim_q[i]);
    exp_ovr = (stim_q.size() > DEPTH);
    check_stats();
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic do_read(input int mode);
    int idx;
    int cyc;
    int n;
    bit r;
    idx = 0;
    cyc = 0;
    n   = exp_q.size();
    rd_ready = 1'b0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("rd_valid_lat1", rd_valid, 0);
    step();
    while (idx < n && cyc < 4 * DEPTH + 16) begin
      chk("rd_valid", rd_valid, 1);
      if (rd_valid !== 1'b1) break;
      chk("rd_data", rd_data, exp_q[idx]);
      chk("rd_last", rd_last, (idx == n - 1));
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      rd_ready = r;
      step();
      cyc++;
      if (r) idx++;
    end
    chk("rd_count", idx, n);
    rd_ready = 1'b0;
    chk("rd_valid_end", rd_valid, 0);
    step();
    chk("rd_valid_idle", rd_valid, 0);
    chk("done_after_rd", done, 1);
  endtask

  initial begin
    // Reset with store_strb held high: no arm after release.
    rst = 1'b1;
    store_strb = 1'b1;
    repeat (3) step();
    check_zero("por");
    rst = 1'b0;
    repeat (2) step();
    fb_valid = 1'b1;
    fb_sgnl  = 13'd55;
    step();
    fb_valid = 1'b0;
    step();
    chk("noarm_n_samples", n_samples, 0);
    chk("noarm_done", done, 0);
    store_strb = 1'b0;
    step();
    // rd_start in IDLE is ignored.
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (3) begin
      step();
      chk("idle_rd_valid", rd_valid, 0);
    end

    // Directed window: 100, -4096, 4095 with oflow 0,1,0.
    stim_q.delete();
    stim_q.push_back(14'h0064);
    stim_q.push_back(14'h3000);
    stim_q.push_back(14'h0FFF);
    run_window(1'b0);
    chk("dir_n_samples", n_samples, 3);
    chk("dir_peak_abs", peak_abs, 4096);
    chk("dir_oflow_cnt", oflow_cnt, 1);
    chk("dir_overrun", overrun, 0);
    do_read(0);
    do_read(1);

    // Over-filled window.
    gen_random(DEPTH + 2);
    run_window(1'b0);
    chk("full_n_samples", n_samples, DEPTH);
    chk("full_overrun", overrun, 1);
    do_read(1);

    // Random windows and random back-pressure.
    for (int k = 0; k < 4; k++) begin
      gen_random($urandom_range(1, DEPTH));
      run_window(1'b0);
      do_read(2);
    end

    // Arm edge during READ aborts the readout.
    gen_random(12);
    run_window(1'b0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    step();
    chk("abort_first_valid", rd_valid, 1);
    chk("abort_first_data", rd_data, exp_q[0]);
    step();
    chk("abort_second_data", rd_data, exp_q[1]);
    store_strb = 1'b1;
    step();
    rd_ready = 1'b0;
    check_zero("abort");
    gen_random(5);
    run_window(1'b1);
    do_read(0);

    // Reset in the middle of a readout.
    gen_random(10);
    run_window(1'b0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_ready = 1'b0;
    check_zero("rst_mid");
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (3) begin
      step();
      chk("rst_rd_valid", rd_valid, 0);
    end
    stim_q.delete();
    stim_q.push_back(14'h1FFF);
    run_window(1'b0);
    chk("one_peak_abs", peak_abs, 1);
    do_read(0);

    // Empty window: rd_start ignored.
    stim_q.delete();
    run_window(1'b0);
    chk("empty_done", done, 1);
    chk("empty_n_samples", n_samples, 0);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    repeat (5) begin
      step();
      chk("empty_rd_valid", rd_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
